// File: rtl/ddram_cp_pkg.sv
// Shared types and constants for the DDRAM copy-port scheduler.
// Optional feature macro: DDRAM_CPSCHED_SUM_EN (adds job checksum port).
package ddram_cp_pkg;
  localparam int BURST_WORDS = 128;
  localparam int BURST_BYTES = 1024;
  localparam int CP_AW = 28;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    ISSUE,
    STREAM,
    GAP,
    DONE
  } state_e;
endpackage

// File: rtl/ddram_cp_beat.sv
// Beat counter plus registered BRAM write port for one copy burst.
// Destination pointer persists across bursts of a job; load restarts it.
module ddram_cp_beat
  import ddram_cp_pkg::*;
#(
  parameter int DST_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic              cpwr,
  input  logic [63:0]       cpdout,
  input  logic [DST_AW-1:0] start_dst,
  output logic              wr,
  output logic              last_beat,
  output logic              bram_we,
  output logic [DST_AW-1:0] bram_addr,
  output logic [63:0]       bram_din
);
  localparam int CW = $clog2(BURST_WORDS) + 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DST_AW-1:0] dst_q, dst_d;
  logic              we_q, we_d;
  logic [DST_AW-1:0] addr_q, addr_d;
  logic [63:0]       din_q, din_d;

  // beats beyond a full burst are dropped
  assign wr = en & cpwr & (cnt_q < CW'(BURST_WORDS));
  assign last_beat = wr & (cnt_q == CW'(BURST_WORDS - 1));

  always_comb begin
    cnt_d  = cnt_q;
    dst_d  = dst_q;
    we_d   = wr;
    addr_d = addr_q;
    din_d  = din_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (load) begin
      dst_d = start_dst;
    end else if (wr) begin
      dst_d = dst_q + 1'b1;
    end
    if (wr) begin
      addr_d = dst_q;
      din_d  = cpdout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dst_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dst_q  <= dst_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
endmodule

// File: rtl/ddram_cp_sched.sv
// Splits a toggle-handshake copy job into 128-word DDRAM copy bursts.
// Define DDRAM_CPSCHED_SUM_EN to add the per-job 32-bit data sum port.
module ddram_cp_sched
  import ddram_cp_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int DST_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_req,
  output logic              job_ack,
  input  logic [27:0]       job_src,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [DST_AW-1:0] job_dst,
  output logic              busy,
  output logic [27:0]       cpaddr,
  output logic              cpreq,
  input  logic              cpbusy,
  input  logic              cpwr,
  input  logic [63:0]       cpdout,
  output logic              bram_we,
  output logic [DST_AW-1:0] bram_addr,
  output logic [63:0]       bram_din
`ifdef DDRAM_CPSCHED_SUM_EN
  ,
  output logic [31:0]       sum
`endif
);
  state_e           state_q, state_d;
  logic [CP_AW-1:0] src_q, src_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             load, clr, en;
  logic             wr, last_beat;
  logic             unused_src_lsb;

  assign unused_src_lsb = &{1'b0, job_src[2:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    len_d   = len_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    load    = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      FLUSH: begin
        if (!cpbusy) state_d = IDLE;
      end
      IDLE: begin
        if (job_req != ack_q) begin
          src_d   = {job_src[27:3], 3'b000};
          len_d   = job_len;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = (job_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        clr = 1'b1;
        if (cpbusy) state_d = STREAM;
      end
      STREAM: begin
        en = 1'b1;
        if (last_beat) state_d = GAP;
      end
      GAP: begin
        // controller must see cpreq low before the next rising edge
        if (!cpbusy) begin
          src_d   = src_q + CP_AW'(BURST_BYTES);
          len_d   = len_q - 1'b1;
          state_d = (len_q == LEN_W'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        ack_d   = job_req;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FLUSH;
      src_q   <= '0;
      len_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  ddram_cp_beat #(.DST_AW(DST_AW)) u_beat (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .load      (load),
    .en        (en),
    .cpwr      (cpwr),
    .cpdout    (cpdout),
    .start_dst (job_dst),
    .wr        (wr),
    .last_beat (last_beat),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din)
  );

`ifdef DDRAM_CPSCHED_SUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load) begin
      sum_d = '0;
    end else if (wr) begin
      sum_d = sum_q + cpdout[63:32] + cpdout[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum = sum_q;
`else
  logic unused_wr;
  assign unused_wr = wr;
`endif

  assign job_ack = ack_q;
  assign busy    = busy_q;
  assign cpreq   = (state_q == ISSUE);
  assign cpaddr  = src_q;
endmodule

// File: tb/tb_ddram_cp_sched.sv
// Randomized scoreboard bench for ddram_cp_sched with a DDRAM copy-port model.
// Sum checks are compiled in when DDRAM_CPSCHED_SUM_EN is defined.
module tb_ddram_cp_sched;
  localparam int LEN_W = 8;
  localparam int DST_AW = 12;
  localparam int BW = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              job_req;
  logic              job_ack;
  logic [27:0]       job_src;
  logic [LEN_W-1:0]  job_len;
  logic [DST_AW-1:0] job_dst;
  logic              busy;
  logic [27:0]       cpaddr;
  logic              cpreq;
  logic              cpbusy;
  logic              cpwr;
  logic [63:0]       cpdout;
  logic              bram_we;
  logic [DST_AW-1:0] bram_addr;
  logic [63:0]       bram_din;
`ifdef DDRAM_CPSCHED_SUM_EN
  logic [31:0]       sum;
`endif

  always #5 clk = ~clk;

  ddram_cp_sched #(.LEN_W(LEN_W), .DST_AW(DST_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .job_req   (job_req),
    .job_ack   (job_ack),
    .job_src   (job_src),
    .job_len   (job_len),
    .job_dst   (job_dst),
    .busy      (busy),
    .cpaddr    (cpaddr),
    .cpreq     (cpreq),
    .cpbusy    (cpbusy),
    .cpwr      (cpwr),
    .cpdout    (cpdout),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din)
`ifdef DDRAM_CPSCHED_SUM_EN
    ,
    .sum       (sum)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DST_AW-1:0] exp_addr_q[$];
  logic [63:0]       exp_data_q[$];
  logic [27:0]       exp_cpaddr_q[$];

  int          req_edges = 0;
  int          writes = 0;
  int          abort_after = -1;
  int          extra_beats = 0;
  bit          flushing = 0;
  bit          abort_done = 0;
  bit          const_data = 0;
  logic [31:0] ref_sum = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every BRAM write is matched against the scoreboard.
  always @(negedge clk) begin
    if (flushing) begin
      check("flush_we", bram_we, 0);
      check("flush_req", cpreq, 0);
    end else if (bram_we) begin
      writes++;
      if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h, expected none", bram_addr);
      end else begin
        check("wr_addr", bram_addr, exp_addr_q.pop_front());
        check("wr_data", bram_din, exp_data_q.pop_front());
      end
    end
  end

  // DDRAM copy-port model: one burst per cpreq rising edge.
  initial begin
    logic prev_req;
    logic [63:0] d;
    cpbusy = 1'b0;
    cpwr = 1'b0;
    cpdout = '0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (cpreq && !prev_req) begin
        req_edges++;
        if (exp_cpaddr_q.size() == 0) fail_now("unexpected_cpreq");
        else check("cpaddr", cpaddr, exp_cpaddr_q.pop_front());
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("req_hold", cpreq, 1);
        cpbusy = 1'b1;
        for (int k = 0; k < BW + extra_beats; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            cpwr = 1'b0;
          end
          @(negedge clk);
          d = const_data ? 64'h00000001_00000002 : {$urandom, $urandom};
          cpwr = 1'b1;
          cpdout = d;
          if (!flushing && k < BW) begin
            exp_data_q.push_back(d);
            ref_sum = ref_sum + d[63:32] + d[31:0];
          end
          if (k == abort_after - 1) begin
            @(negedge clk);
            cpwr = 1'b0;
            repeat (3) @(negedge clk);
            reset = 1'b1;
            job_req = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            flushing = 1'b1;
          end
        end
        @(negedge clk);
        cpwr = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("gap_req_low", cpreq, 0);
        cpbusy = 1'b0;
        if (flushing) begin
          repeat (4) @(negedge clk);
          flushing = 1'b0;
          abort_done = 1'b1;
        end
      end
      prev_req = cpreq;
    end
  end

  task automatic issue(logic [27:0] src, int len, logic [DST_AW-1:0] dst);
    logic [27:0] base;
    base = {src[27:3], 3'b000};
    for (int i = 0; i < len; i++) exp_cpaddr_q.push_back(base + 28'(i * 1024));
    for (int i = 0; i < len * BW; i++) exp_addr_q.push_back(dst + DST_AW'(i));
    ref_sum = '0;
    @(negedge clk);
    job_src = src;
    job_len = LEN_W'(len);
    job_dst = dst;
    job_req = ~job_req;
  endtask

  task automatic run_job(logic [27:0] src, int len, logic [DST_AW-1:0] dst);
    int e0, w0, cyc, lim;
    logic prev_busy;
    e0 = req_edges;
    w0 = writes;
    cyc = 0;
    lim = 60 + len * 500;
    prev_busy = 1'b0;
    issue(src, len, dst);
    while (job_ack !== job_req && cyc < lim) begin
      prev_busy = busy;
      @(negedge clk);
      job_src = 28'($urandom);
      job_len = LEN_W'($urandom);
      job_dst = DST_AW'($urandom);
      cyc++;
    end
    if (job_ack !== job_req) begin
      fail_now("job_ack_timeout");
    end else begin
      check("busy_at_ack", busy, 0);
      check("busy_before_ack", prev_busy, 1);
      if (len == 0) check("len0_latency_ok", cyc <= 3, 1);
`ifdef DDRAM_CPSCHED_SUM_EN
      check("sum", sum, ref_sum);
`endif
    end
    check("req_edges", req_edges - e0, len);
    check("write_count", writes - w0, len * BW);
    check("addr_q_empty", exp_addr_q.size(), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_cpaddr_q.delete();
  endtask

  initial begin
    int w0, cyc;
    reset = 1'b1;
    job_req = 1'b0;
    job_src = '0;
    job_len = '0;
    job_dst = '0;
    repeat (3) @(negedge clk);
    check("rst_job_ack", job_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_cpreq", cpreq, 0);
    check("rst_cpaddr", cpaddr, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_bram_din", bram_din, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_job(28'h0000400, 1, 12'h010);
    run_job(28'h0001003, 3, 12'h200);
    run_job(28'h0000000, 1, 12'hFC0);
    run_job(28'h0123450, 0, 12'h123);
    extra_beats = 3;
    run_job(28'($urandom), 1, DST_AW'($urandom));
    extra_beats = 0;
    run_job(28'hFFFFC07, 2, 12'hF80);

    // reset in the middle of a burst, controller keeps streaming
    abort_after = 50;
    w0 = writes;
    issue(28'h0002000, 1, 12'h300);
    cyc = 0;
    while (!abort_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!abort_done) fail_now("abort_timeout");
    check("abort_writes", writes - w0, 50);
    check("abort_data_q", exp_data_q.size(), 0);
    check("abort_ack", job_ack, 0);
    check("abort_busy", busy, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_cpaddr_q.delete();
    abort_after = -1;
    abort_done = 1'b0;
    run_job(28'h0004008, 2, 12'h040);

    for (int j = 0; j < 4; j++)
      run_job(28'($urandom), $urandom_range(0, 2), DST_AW'($urandom));

`ifdef DDRAM_CPSCHED_SUM_EN
    const_data = 1'b1;
    run_job(28'h0000800, 1, 12'h000);
    check("sum_const", sum, 32'h180);
    const_data = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
